// File: rtl/channel_pkg.sv
// Shared definitions for the NeoPixel channel controller command decoder.
// Holds the SPI command opcodes, the decoder state encoding and the
// config register file address map.
package channel_pkg;

    typedef enum logic [7:0] {
        CONF_WR = 8'h2A,
        ADDR_WR = 8'h2B,
        DATA_WR = 8'h2C,
        CONF_RD = 8'h2D
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONF_WR,
        ST_ADDR_WR,
        ST_DATA_WR,
        ST_CONF_RD
    } state_e;

    localparam logic [2:0] REG_T0H      = 3'd0;
    localparam logic [2:0] REG_T0L      = 3'd1;
    localparam logic [2:0] REG_T1H      = 3'd2;
    localparam logic [2:0] REG_T1L      = 3'd3;
    localparam logic [2:0] REG_CHAN_LEN = 3'd4;
    localparam logic [2:0] REG_CHAN_CNT = 3'd5;
    localparam logic [2:0] REG_NUM      = 3'd6;

endpackage

// File: rtl/channel_regfile.sv
// Config register file: six 8-bit registers.
// Ports:
//   clk_i, rst_n_i       clock, async active-low reset
//   wr_en_i/addr/data    write port, written on the clock edge
//   rd_en_i/rd_addr_i    read request; rd_data_o is registered (0 for addr 6,7)
//   reg_*_o              direct register outputs (chan_cnt is bits [3:0] of reg 5)
module channel_regfile
    import channel_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       wr_en_i,
    input  logic [2:0] wr_addr_i,
    input  logic [7:0] wr_data_i,
    input  logic       rd_en_i,
    input  logic [2:0] rd_addr_i,
    output logic [7:0] rd_data_o,
    output logic [7:0] reg_t0h_o,
    output logic [7:0] reg_t0l_o,
    output logic [7:0] reg_t1h_o,
    output logic [7:0] reg_t1l_o,
    output logic [7:0] reg_chan_len_o,
    output logic [3:0] reg_chan_cnt_o
);

    logic [7:0] regs_q [6];
    logic [7:0] rd_data_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < 6; i++) begin
                regs_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            if (wr_en_i && (wr_addr_i < REG_NUM)) begin
                regs_q[wr_addr_i] <= wr_data_i;
            end
            if (rd_en_i) begin
                rd_data_q <= (rd_addr_i < REG_NUM) ? regs_q[rd_addr_i] : '0;
            end
        end
    end

    assign rd_data_o      = rd_data_q;
    assign reg_t0h_o      = regs_q[REG_T0H];
    assign reg_t0l_o      = regs_q[REG_T0L];
    assign reg_t1h_o      = regs_q[REG_T1H];
    assign reg_t1l_o      = regs_q[REG_T1L];
    assign reg_chan_len_o = regs_q[REG_CHAN_LEN];
    assign reg_chan_cnt_o = regs_q[REG_CHAN_CNT][3:0];

endmodule

// File: rtl/channel_ctl_top.sv
// Byte-level SPI command decoder for the NeoPixel LED controller.
// Command bytes (dc_i=0) select the operation; data bytes (dc_i=1) are routed
// to the config regfile (write/readback) or to the 16 channel colour RAMs.
// Ports:
//   clk_i, rst_n_i                 clock, async active-low reset
//   dc_i, spi_byte_vld_i, spi_byte_data_i   incoming SPI byte and framing
//   reg_rd_data_o                  registered regfile readback
//   reg_t0h/t0l/t1h/t1l/chan_len/chan_cnt_o  live config registers
//   ram_wr_en_o/addr_o/byte_en_o   combinational RAM write strobe for the current data byte
//   ram_wr_done_o                  one-cycle pulse after the last byte of a frame
module channel_ctl_top
    import channel_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        dc_i,
    input  logic        spi_byte_vld_i,
    input  logic [7:0]  spi_byte_data_i,
    output logic [7:0]  reg_rd_data_o,
    output logic [7:0]  reg_t0h_o,
    output logic [7:0]  reg_t0l_o,
    output logic [7:0]  reg_t1h_o,
    output logic [7:0]  reg_t1l_o,
    output logic [7:0]  reg_chan_len_o,
    output logic [3:0]  reg_chan_cnt_o,
    output logic [15:0] ram_wr_en_o,
    output logic [7:0]  ram_wr_addr_o,
    output logic [3:0]  ram_wr_byte_en_o,
    output logic        ram_wr_done_o
);

    state_e     state_q;
    logic [2:0] wr_addr_q;
    logic [2:0] rd_addr_q;
    logic [1:0] byte_q;
    logic [7:0] led_q;
    logic [3:0] chan_q;
    logic       done_q;

    logic cmd_stb;
    logic data_stb;
    logic reg_wr_en;
    logic reg_rd_en;
    logic ram_stb;
    logic last_byte;

    assign cmd_stb   = spi_byte_vld_i && !dc_i;
    assign data_stb  = spi_byte_vld_i && dc_i;
    assign reg_wr_en = data_stb && (state_q == ST_CONF_WR) && (wr_addr_q < REG_NUM);
    assign reg_rd_en = data_stb && (state_q == ST_CONF_RD);
    assign ram_stb   = data_stb && (state_q == ST_DATA_WR);
    assign last_byte = (byte_q == 2'd2) && (led_q == reg_chan_len_o)
                       && (chan_q == reg_chan_cnt_o);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            byte_q    <= '0;
            led_q     <= '0;
            chan_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (cmd_stb) begin
                wr_addr_q <= '0;
                rd_addr_q <= '0;
                byte_q    <= '0;
                led_q     <= '0;
                chan_q    <= '0;
                case (spi_byte_data_i)
                    CONF_WR: state_q <= ST_CONF_WR;
                    ADDR_WR: state_q <= ST_ADDR_WR;
                    DATA_WR: state_q <= ST_DATA_WR;
                    CONF_RD: state_q <= ST_CONF_RD;
                    default: state_q <= ST_IDLE;
                endcase
            end else if (data_stb) begin
                case (state_q)
                    ST_CONF_WR: begin
                        if (wr_addr_q < REG_NUM) begin
                            wr_addr_q <= wr_addr_q + 3'd1;
                        end
                    end
                    ST_CONF_RD: begin
                        rd_addr_q <= rd_addr_q + 3'd1;
                    end
                    ST_DATA_WR: begin
                        if (last_byte) begin
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                            byte_q  <= '0;
                            led_q   <= '0;
                            chan_q  <= '0;
                        end else if (byte_q == 2'd2) begin
                            byte_q <= '0;
                            if (led_q == reg_chan_len_o) begin
                                led_q  <= '0;
                                chan_q <= chan_q + 4'd1;
                            end else begin
                                led_q <= led_q + 8'd1;
                            end
                        end else begin
                            byte_q <= byte_q + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // RAM strobes are combinational so the RAM captures the byte in the same cycle it is presented.
    assign ram_wr_en_o      = ram_stb ? (16'b1 << chan_q) : '0;
    assign ram_wr_addr_o    = ram_stb ? led_q : '0;
    assign ram_wr_byte_en_o = ram_stb ? (4'b1 << byte_q) : '0;
    assign ram_wr_done_o    = done_q;

    channel_regfile u_regfile (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .wr_en_i        (reg_wr_en),
        .wr_addr_i      (wr_addr_q),
        .wr_data_i      (spi_byte_data_i),
        .rd_en_i        (reg_rd_en),
        .rd_addr_i      (rd_addr_q),
        .rd_data_o      (reg_rd_data_o),
        .reg_t0h_o      (reg_t0h_o),
        .reg_t0l_o      (reg_t0l_o),
        .reg_t1h_o      (reg_t1h_o),
        .reg_t1l_o      (reg_t1l_o),
        .reg_chan_len_o (reg_chan_len_o),
        .reg_chan_cnt_o (reg_chan_cnt_o)
    );

endmodule

// File: tb/tb_channel_ctl_top.sv
module tb_channel_ctl_top;

    logic        clk;
    logic        rst_n;
    logic        dc;
    logic        vld;
    logic [7:0]  data;
    logic [7:0]  rd_data;
    logic [7:0]  t0h, t0l, t1h, t1l, chan_len;
    logic [3:0]  chan_cnt;
    logic [15:0] wr_en;
    logic [7:0]  wr_addr;
    logic [3:0]  wr_be;
    logic        wr_done;

    int checks = 0;
    int errors = 0;

    logic [15:0] cap_en;
    logic [7:0]  cap_addr;
    logic [3:0]  cap_be;
    logic        cap_done;
    logic [7:0]  cap_rd;

    channel_ctl_top dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .dc_i             (dc),
        .spi_byte_vld_i   (vld),
        .spi_byte_data_i  (data),
        .reg_rd_data_o    (rd_data),
        .reg_t0h_o        (t0h),
        .reg_t0l_o        (t0l),
        .reg_t1h_o        (t1h),
        .reg_t1l_o        (t1l),
        .reg_chan_len_o   (chan_len),
        .reg_chan_cnt_o   (chan_cnt),
        .ram_wr_en_o      (wr_en),
        .ram_wr_addr_o    (wr_addr),
        .ram_wr_byte_en_o (wr_be),
        .ram_wr_done_o    (wr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one byte for exactly one clock edge; capture the combinational
    // RAM strobes during the byte and the registered outputs after the edge.
    task automatic drive(input logic d_c, input logic [7:0] d);
        @(negedge clk);
        dc   = d_c;
        vld  = 1'b1;
        data = d;
        #1;
        cap_en   = wr_en;
        cap_addr = wr_addr;
        cap_be   = wr_be;
        @(posedge clk);
        #1;
        vld      = 1'b0;
        cap_done = wr_done;
        cap_rd   = rd_data;
    endtask

    task automatic check_regs(input string tag);
        logic [47:0] act;
        act = {t0h, t0l, t1h, t1l, chan_len, 4'h0, chan_cnt};
        checks++;
        if (act !== 48'h01_12_23_34_3F_07) begin
            errors++;
            $display("FAIL %s regs: got %h expected 01122334 3f07", tag, act);
        end
    endtask

    task automatic test_reset();
        logic [88:0] act;
        rst_n = 1'b0; dc = 1'b0; vld = 1'b0; data = '0;
        repeat (3) @(posedge clk);
        #1;
        act = {rd_data, t0h, t0l, t1h, t1l, chan_len, chan_cnt, wr_en, wr_addr, wr_be, wr_done};
        checks++;
        if (act !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", act);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_conf_wr();
        logic [7:0] vals [6];
        vals = '{8'h01, 8'h12, 8'h23, 8'h34, 8'h3F, 8'h07};
        drive(1'b0, 8'h2A);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, vals[i]);
            checks++;
            if (cap_en !== 16'h0) begin
                errors++;
                $display("FAIL conf_wr_no_ram: got %h expected 0000", cap_en);
            end
        end
        check_regs("conf_wr");
        drive(1'b1, 8'hFF);
        check_regs("conf_wr_extra");
    endtask

    task automatic test_conf_rd();
        logic [7:0] exp [8];
        exp = '{8'h01, 8'h12, 8'h23, 8'h34, 8'h3F, 8'h07, 8'h00, 8'h00};
        drive(1'b0, 8'h2D);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'hA5);
            checks++;
            if (cap_rd !== exp[i]) begin
                errors++;
                $display("FAIL conf_rd[%0d]: got %h expected %h", i, cap_rd, exp[i]);
            end
        end
        // Wraps back to reg0
        drive(1'b1, 8'hA5);
        checks++;
        if (cap_rd !== 8'h01) begin
            errors++;
            $display("FAIL conf_rd_wrap: got %h expected 01", cap_rd);
        end
    endtask

    task automatic test_addr_wr();
        int bad;
        bad = 0;
        drive(1'b0, 8'h2B);
        for (int i = 0; i < 512; i++) begin
            drive(1'b1, 8'(i));
            if (cap_en !== 16'h0 || cap_be !== 4'h0 || cap_done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL addr_wr_no_ram: got %0d strobed bytes expected 0", bad);
        end
        check_regs("addr_wr");
    endtask

    task automatic test_data_wr();
        logic [15:0] e_en;
        logic [7:0]  e_addr;
        logic [3:0]  e_be;
        int dones;
        dones = 0;
        drive(1'b0, 8'h2C);
        for (int i = 0; i < 1536; i++) begin
            drive(1'b1, 8'(i % 255));
            e_en   = 16'b1 << (i / 192);
            e_addr = 8'((i / 3) % 64);
            e_be   = 4'b1 << (i % 3);
            checks++;
            if (cap_en !== e_en || cap_addr !== e_addr || cap_be !== e_be) begin
                errors++;
                $display("FAIL data_wr[%0d]: got en=%h addr=%h be=%b expected en=%h addr=%h be=%b",
                         i, cap_en, cap_addr, cap_be, e_en, e_addr, e_be);
            end
            if (cap_done === 1'b1) dones++;
            if (i == 1535) begin
                checks++;
                if (cap_done !== 1'b1) begin
                    errors++;
                    $display("FAIL data_wr_done_last: got %b expected 1", cap_done);
                end
            end
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL data_wr_done_count: got %0d expected 1", dones);
        end
        drive(1'b1, 8'h55);
        checks++;
        if (cap_en !== 16'h0 || cap_be !== 4'h0 || cap_done !== 1'b0) begin
            errors++;
            $display("FAIL data_wr_after_done: got en=%h be=%b done=%b expected 0 0 0",
                     cap_en, cap_be, cap_done);
        end
        check_regs("data_wr");
    endtask

    task automatic test_restart();
        int dones;
        dones = 0;
        drive(1'b0, 8'h2C);
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 8'(i));
            if (cap_done === 1'b1) dones++;
        end
        drive(1'b0, 8'h2C);
        if (cap_done === 1'b1) dones++;
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL restart_no_done: got %0d pulses expected 0", dones);
        end
        drive(1'b1, 8'h11);
        checks++;
        if (cap_en !== 16'h0001 || cap_addr !== 8'h00 || cap_be !== 4'b0001) begin
            errors++;
            $display("FAIL restart_first: got en=%h addr=%h be=%b expected 0001 00 0001",
                     cap_en, cap_addr, cap_be);
        end
        drive(1'b1, 8'h22);
        checks++;
        if (cap_en !== 16'h0001 || cap_addr !== 8'h00 || cap_be !== 4'b0010) begin
            errors++;
            $display("FAIL restart_second: got en=%h addr=%h be=%b expected 0001 00 0010",
                     cap_en, cap_addr, cap_be);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [88:0] act;
        drive(1'b0, 8'h2C);
        for (int i = 0; i < 10; i++) drive(1'b1, 8'(i));
        @(negedge clk);
        dc = 1'b1; vld = 1'b1; data = 8'h77;
        #1;
        checks++;
        if (wr_en !== 16'h0001 || wr_addr !== 8'h03 || wr_be !== 4'b0010) begin
            errors++;
            $display("FAIL mid_frame_strobe: got en=%h addr=%h be=%b expected 0001 03 0010",
                     wr_en, wr_addr, wr_be);
        end
        rst_n = 1'b0;
        #1;
        act = {rd_data, t0h, t0l, t1h, t1l, chan_len, chan_cnt, wr_en, wr_addr, wr_be, wr_done};
        checks++;
        if (act !== '0) begin
            errors++;
            $display("FAIL reset_mid_frame: got %h expected 0", act);
        end
        vld = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (wr_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: got %b expected 0", wr_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 8'h01);
        checks++;
        if (cap_en !== 16'h0) begin
            errors++;
            $display("FAIL post_reset_idle: got %h expected 0000", cap_en);
        end
    endtask

    initial begin
        test_reset();
        test_conf_wr();
        test_conf_rd();
        test_addr_wr();
        test_data_wr();
        test_restart();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
